barrel_rotator: RTL and testbench
=================================

Name: barrel_rotator

Overview:
- Registered barrel rotator for a WIDTH-bit data word.
- Rotates the input left or right by 0..WIDTH-1 positions in one clock cycle, using a logarithmic mux tree (one stage per amount bit).
- Used as a datapath utility between operand registers and ALU/packing logic.
- Output is registered with a valid flag so it can sit directly in a pipeline.

Parameters:
- WIDTH, 8, data width in bits. Must be a power of two and at least 2.
- AMT_W, $clog2(WIDTH) (derived localparam, not overridable), width of the rotate amount.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  qualifies a, amt, lr this cycle
- a  input  WIDTH  data to rotate
- amt  input  AMT_W  rotate distance, unsigned
- lr  input  1  direction: 0 = rotate right (toward LSB), 1 = rotate left (toward MSB)
- mout  output  WIDTH  registered rotated result
- out_valid  output  1  mout holds a fresh result from the previous accepted input

Behaviour:
- Reset: asserting rst clears mout to 0 and out_valid to 0 immediately, with no dependence on clk. Both stay cleared while rst is high.
- Core function, right rotate (lr=0): mout[i] = a[(i+amt) mod WIDTH].
- Core function, left rotate (lr=1): mout[i] = a[(i-amt) mod WIDTH].
- Implementation: AMT_W cascaded stages. Stage k rotates by 2^k when amt[k]=1 and passes data through otherwise. Direction is applied uniformly to every stage.
- No bits are lost: every output bit comes from the input word.
- amt=0 passes a through unchanged for either lr value.
- amt=WIDTH/2 gives the same result for lr=0 and lr=1.
- Latency is 1 cycle. On a rising clk edge with in_valid=1, mout is loaded with rotate(a, amt, lr) and out_valid is set to 1.
- On a rising clk edge with in_valid=0, mout holds its previous value and out_valid is set to 0.
- Throughput: one result per cycle. There is no backpressure; the consumer must accept out_valid pulses as they occur.
- Reset takes priority over clk. Deasserting rst mid-stream drops any input presented during reset. The first valid result appears one edge after the first accepted in_valid.
- There are no combinational paths from inputs to outputs.
- X-free after reset: mout is driven only from the reset value or from a registered computation.

Optional Feature:
- Macro: BARREL_ROTATOR_SHIFT_MODES_EN.
- Defined: adds input port mode [1:0], sampled together with a when in_valid=1.
  - 00: rotate, as specified above.
  - 01: logical shift. Vacated positions fill with 0 in either direction.
  - 10: arithmetic shift. For lr=0, vacated MSBs fill with a[WIDTH-1]. For lr=1, behaves exactly as a logical left shift.
  - 11: reserved. Behaves exactly as 00.
- Not defined: the mode port does not exist and the block is rotate-only. Behaviour is then identical to the defined case with mode=00.

Test Plan:
- Reset: hold rst=1 with random inputs and clock running -> mout=00000000, out_valid=0. Assert rst asynchronously mid-cycle -> outputs clear without waiting for a clk edge.
- Right rotate, a=10101010, lr=0, in_valid=1:
  - amt=0 -> 10101010
  - amt=1 -> 01010101
  - amt=2 -> 10101010
  - amt=4 -> 10101010
  - Each result appears one edge later with out_valid=1.
- Left rotate, a=10101010, lr=1:
  - amt=1 -> 01010101
  - amt=2 -> 10101010
  - amt=4 -> 10101010
- Asymmetric pattern, a=10000001:
  - lr=0, amt=3 -> 00110000
  - lr=1, amt=3 -> 00001100
  - lr=0, amt=7 -> 00000011
  - lr=1, amt=7 -> 11000000
- Valid/hold: present one valid op, then hold in_valid=0 for 3 cycles with a changing -> mout holds the last result and out_valid goes 0 after the first edge. Back-to-back valid inputs produce back-to-back results in order.
- With BARREL_ROTATOR_SHIFT_MODES_EN defined, a=10010110, amt=2:
  - mode=01, lr=0 -> 00100101
  - mode=10, lr=0 -> 11100101
  - mode=01, lr=1 -> 01011000
  - mode=11, lr=0 -> 10100101

Source files
------------

// File: rtl/barrel_rotator_if.sv
// Bus bundle for barrel_rotator: input operands plus registered result.
// The mode field is present only when BARREL_ROTATOR_SHIFT_MODES_EN is defined.
interface barrel_rotator_if #(
  parameter int WIDTH = 8
);
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amt;
  logic             lr;
  logic [WIDTH-1:0] mout;
  logic             out_valid;

`ifdef BARREL_ROTATOR_SHIFT_MODES_EN
  logic [1:0]       mode;

  modport master (output in_valid, a, amt, lr, mode, input mout, out_valid);
  modport slave  (input in_valid, a, amt, lr, mode, output mout, out_valid);
`else
  modport master (output in_valid, a, amt, lr, input mout, out_valid);
  modport slave  (input in_valid, a, amt, lr, output mout, out_valid);
`endif
endinterface

// File: rtl/barrel_rotator.sv
// Registered logarithmic barrel rotator, one mux stage per amount bit.
// Defining BARREL_ROTATOR_SHIFT_MODES_EN adds logical/arithmetic shift modes.
module barrel_rotator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  barrel_rotator_if.slave  bus
);
  localparam int AMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mout_q, mout_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result;
  logic             shift_en;
  logic             arith_en;

  always_comb begin
    shift_en = 1'b0;
    arith_en = 1'b0;
`ifdef BARREL_ROTATOR_SHIFT_MODES_EN
    // 11 is reserved and falls back to rotate
    shift_en = (bus.mode == 2'b01) || (bus.mode == 2'b10);
    arith_en = (bus.mode == 2'b10) && !bus.lr;
`endif
  end

  // Shifts compose across stages: the sign fill reuses the current MSB,
  // which every right-shift stage keeps equal to the original a[WIDTH-1].
  always_comb begin
    logic [WIDTH-1:0] stg;
    logic [WIDTH-1:0] wrap;
    logic [WIDTH-1:0] fill;
    stg = bus.a;
    for (int k = 0; k < AMT_W; k++) begin
      wrap = '0;
      fill = '0;
      if (bus.amt[k]) begin
        if (bus.lr) begin
          if (!shift_en) wrap = stg >> (WIDTH - (1 << k));
          stg = (stg << (1 << k)) | wrap;
        end else begin
          if (!shift_en) wrap = stg << (WIDTH - (1 << k));
          if (arith_en && stg[WIDTH-1]) fill = ~({WIDTH{1'b1}} >> (1 << k));
          stg = (stg >> (1 << k)) | wrap | fill;
        end
      end
    end
    result = stg;
  end

  always_comb begin
    mout_d      = mout_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) mout_d = result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mout_q      <= mout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.mout      = mout_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_barrel_rotator.sv
// Directed self-checking bench for barrel_rotator (WIDTH=8).
module tb_barrel_rotator;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  barrel_rotator_if #(.WIDTH(8)) bus ();

  barrel_rotator #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic vld, input logic [7:0] a, input logic [2:0] amt,
                       input logic lr, input logic [1:0] mode);
    @(negedge clk);
    bus.in_valid = vld;
    bus.a        = a;
    bus.amt      = amt;
    bus.lr       = lr;
`ifdef BARREL_ROTATOR_SHIFT_MODES_EN
    bus.mode     = mode;
`else
    if (mode != 2'b00) $display("note: mode %b ignored in rotate-only build", mode);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp_m, input logic exp_v);
    tests++;
    assert (bus.mout === exp_m && bus.out_valid === exp_v)
    else begin
      fails++;
      $error("FAIL %s: mout=%b out_valid=%b, expected mout=%b out_valid=%b",
             tag, bus.mout, bus.out_valid, exp_m, exp_v);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.amt      = '0;
    bus.lr       = 1'b0;
`ifdef BARREL_ROTATOR_SHIFT_MODES_EN
    bus.mode     = 2'b00;
`endif
    rst = 1'b1;
    #1;
    chk("reset_initial", 8'h00, 1'b0);

    // random valid inputs while reset is held must not load anything
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 2'b00);
      chk("reset_hold", 8'h00, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    // right rotate
    drive(1'b1, 8'b10101010, 3'd0, 1'b0, 2'b00); chk("r_amt0", 8'b10101010, 1'b1);
    drive(1'b1, 8'b10101010, 3'd1, 1'b0, 2'b00); chk("r_amt1", 8'b01010101, 1'b1);
    drive(1'b1, 8'b10101010, 3'd2, 1'b0, 2'b00); chk("r_amt2", 8'b10101010, 1'b1);
    drive(1'b1, 8'b10101010, 3'd4, 1'b0, 2'b00); chk("r_amt4", 8'b10101010, 1'b1);

    // left rotate
    drive(1'b1, 8'b10101010, 3'd1, 1'b1, 2'b00); chk("l_amt1", 8'b01010101, 1'b1);
    drive(1'b1, 8'b10101010, 3'd2, 1'b1, 2'b00); chk("l_amt2", 8'b10101010, 1'b1);
    drive(1'b1, 8'b10101010, 3'd4, 1'b1, 2'b00); chk("l_amt4", 8'b10101010, 1'b1);

    // asymmetric pattern
    drive(1'b1, 8'b10000001, 3'd3, 1'b0, 2'b00); chk("asym_r3", 8'b00110000, 1'b1);
    drive(1'b1, 8'b10000001, 3'd3, 1'b1, 2'b00); chk("asym_l3", 8'b00001100, 1'b1);
    drive(1'b1, 8'b10000001, 3'd7, 1'b0, 2'b00); chk("asym_r7", 8'b00000011, 1'b1);
    drive(1'b1, 8'b10000001, 3'd7, 1'b1, 2'b00); chk("asym_l7", 8'b11000000, 1'b1);
    drive(1'b1, 8'b00010110, 3'd0, 1'b1, 2'b00); chk("l_amt0", 8'b00010110, 1'b1);
    drive(1'b1, 8'b00010110, 3'd5, 1'b0, 2'b00); chk("r_amt5", 8'b10110000, 1'b1);
    drive(1'b1, 8'b00010110, 3'd6, 1'b1, 2'b00); chk("l_amt6", 8'b10000101, 1'b1);
    drive(1'b1, 8'b00010110, 3'd4, 1'b1, 2'b00); chk("l_half", 8'b01100001, 1'b1);

    // hold: in_valid low with a changing keeps the last result
    drive(1'b1, 8'b11010010, 3'd1, 1'b0, 2'b00); chk("hold_load", 8'b01101001, 1'b1);
    drive(1'b0, 8'b11111111, 3'd3, 1'b1, 2'b00); chk("hold_1", 8'b01101001, 1'b0);
    drive(1'b0, 8'b00001111, 3'd2, 1'b0, 2'b00); chk("hold_2", 8'b01101001, 1'b0);
    drive(1'b0, 8'b01010000, 3'd5, 1'b1, 2'b00); chk("hold_3", 8'b01101001, 1'b0);

    // asynchronous reset mid-cycle clears outputs before any edge
    drive(1'b1, 8'b00000001, 3'd1, 1'b1, 2'b00); chk("pre_async", 8'b00000010, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 8'h00, 1'b0);
    drive(1'b1, 8'b11110000, 3'd2, 1'b0, 2'b00); chk("async_hold", 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_idle", 8'h00, 1'b0);
    drive(1'b1, 8'b11110000, 3'd2, 1'b0, 2'b00); chk("post_reset_first", 8'b00111100, 1'b1);

`ifdef BARREL_ROTATOR_SHIFT_MODES_EN
    drive(1'b1, 8'b10010110, 3'd2, 1'b0, 2'b01); chk("lsr2", 8'b00100101, 1'b1);
    drive(1'b1, 8'b10010110, 3'd2, 1'b0, 2'b10); chk("asr2", 8'b11100101, 1'b1);
    drive(1'b1, 8'b10010110, 3'd2, 1'b1, 2'b01); chk("lsl2", 8'b01011000, 1'b1);
    drive(1'b1, 8'b10010110, 3'd2, 1'b0, 2'b11); chk("rsv_rot", 8'b10100101, 1'b1);
    drive(1'b1, 8'b10010110, 3'd7, 1'b0, 2'b10); chk("asr7", 8'b11111111, 1'b1);
    drive(1'b1, 8'b10010110, 3'd3, 1'b1, 2'b10); chk("asl3", 8'b10110000, 1'b1);
    drive(1'b1, 8'b01010110, 3'd5, 1'b0, 2'b10); chk("asr5_pos", 8'b00000010, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
